// File: rtl/calibration_sequencer.sv
// calibration_sequencer
//   Sweeps ADC channels 0..ADC_COUNT-1 through an external measurement block.
//   For each channel it issues one command strobe, waits for the block to
//   report busy and then not-busy, and stores the signed mean it returns.
//   After a full sweep it registers the spread (max - min) of the means and
//   pulses done. While idle the processor CSR strobe/command pass straight
//   through to the measurement block.
//
// Ports
//   sysClk, sysReset_n    clock; synchronous active-low reset
//   start                 one-cycle pulse, begins a sweep (ignored unless idle)
//   trainingOn            copied into command bit 30
//   cpuStrobe, cpuCommand processor access, passed through while idle
//   calStrobe, calCommand strobe/command to the measurement block
//   calReadout            status: bit 31 busy, low RESULT_WIDTH bits mean
//   resultSel/resultValue registered readback of stored channel means
//   spread                signed max-min of last complete sweep
//   busy, done            sequencer active; one-cycle sweep-complete pulse
//   timeoutError          sticky watchdog abort flag
//
// Configuration
//   CALIBRATION_SEQUENCER_TIMEOUT_EN  when defined, a watchdog aborts a sweep
//   if one measurement waits TIMEOUT_CYCLES cycles; otherwise waits are
//   unbounded and timeoutError stays 0.
module calibration_sequencer #(
   parameter int ADC_COUNT      = 8,
   parameter int RESULT_WIDTH   = 16,
   parameter int TIMEOUT_CYCLES = 67108864
) (
   input  logic                    sysClk,
   input  logic                    sysReset_n,
   input  logic                    start,
   input  logic                    trainingOn,
   input  logic                    cpuStrobe,
   input  logic [31:0]             cpuCommand,
   output logic                    calStrobe,
   output logic [31:0]             calCommand,
   input  logic [31:0]             calReadout,
   input  logic [3:0]              resultSel,
   output logic [RESULT_WIDTH-1:0] resultValue,
   output logic [RESULT_WIDTH:0]   spread,
   output logic                    busy,
   output logic                    done,
   output logic                    timeoutError
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_CAPTURE   = 3'd4;
   localparam logic [2:0] S_NEXT      = 3'd5;

   localparam logic [3:0] LAST_CH = 4'(ADC_COUNT - 1);

   logic [2:0]                     state_q, state_d;
   logic [3:0]                     channel_q, channel_d;
   // Full 16-entry table: entries at or above ADC_COUNT are never written,
   // so they keep their reset value of zero.
   logic [RESULT_WIDTH-1:0]        result_q [16];
   logic [RESULT_WIDTH-1:0]        result_d [16];
   logic signed [RESULT_WIDTH-1:0] min_q, min_d, max_q, max_d;
   logic [RESULT_WIDTH:0]          spread_q, spread_d;
   logic                           done_q, done_d;
   logic                           timeout_error_q, timeout_error_d;
   logic [RESULT_WIDTH-1:0]        result_value_q, result_value_d;

   logic signed [RESULT_WIDTH-1:0] mean;
   logic                           waiting;
   logic                           wd_expired;
   logic                           unused_readout;

   assign mean           = calReadout[RESULT_WIDTH-1:0];
   assign waiting        = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
   assign unused_readout = ^calReadout;

`ifdef CALIBRATION_SEQUENCER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wdog_q, wdog_d;

   // Expires during the TIMEOUT_CYCLES-th consecutive wait cycle.
   assign wd_expired = waiting && (wdog_q == WD_LAST);

   always_comb begin
      wdog_d = wdog_q;
      if (state_q == S_ISSUE) begin
         wdog_d = '0;
      end else if (waiting) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge sysClk) begin
      if (!sysReset_n) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      channel_d       = channel_q;
      result_d        = result_q;
      min_d           = min_q;
      max_d           = max_q;
      spread_d        = spread_q;
      done_d          = 1'b0;
      timeout_error_d = timeout_error_q;
      calStrobe       = 1'b0;
      calCommand      = '0;

      case (state_q)
         S_IDLE: begin
            calStrobe  = cpuStrobe;
            calCommand = cpuCommand;
            if (start) begin
               state_d         = S_ISSUE;
               channel_d       = '0;
               timeout_error_d = 1'b0;
            end
         end
         S_ISSUE: begin
            calStrobe  = 1'b1;
            calCommand = {1'b1, trainingOn, 2'b00, channel_q, 24'h000000};
            state_d    = S_WAIT_BUSY;
         end
         // Waiting for busy first keeps a stale not-busy status from the
         // previous measurement from being captured as this channel's result.
         S_WAIT_BUSY: begin
            if (wd_expired) begin
               state_d         = S_IDLE;
               timeout_error_d = 1'b1;
            end else if (calReadout[31]) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (wd_expired) begin
               state_d         = S_IDLE;
               timeout_error_d = 1'b1;
            end else if (!calReadout[31]) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            result_d[channel_q] = calReadout[RESULT_WIDTH-1:0];
            if (channel_q == 4'd0) begin
               min_d = mean;
               max_d = mean;
            end else begin
               if (mean < min_q) min_d = mean;
               if (mean > max_q) max_d = mean;
            end
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (channel_q == LAST_CH) begin
               state_d  = S_IDLE;
               spread_d = {max_q[RESULT_WIDTH-1], max_q} - {min_q[RESULT_WIDTH-1], min_q};
               done_d   = 1'b1;
            end else begin
               channel_d = channel_q + 4'd1;
               state_d   = S_ISSUE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      result_value_d = '0;
      if ({1'b0, resultSel} < 5'(ADC_COUNT)) begin
         result_value_d = result_q[resultSel];
      end
   end

   always_ff @(posedge sysClk) begin
      if (!sysReset_n) begin
         state_q         <= S_IDLE;
         channel_q       <= '0;
         for (int unsigned i = 0; i < 16; i++) begin
            result_q[i] <= '0;
         end
         min_q           <= '0;
         max_q           <= '0;
         spread_q        <= '0;
         done_q          <= 1'b0;
         timeout_error_q <= 1'b0;
         result_value_q  <= '0;
      end else begin
         state_q         <= state_d;
         channel_q       <= channel_d;
         result_q        <= result_d;
         min_q           <= min_d;
         max_q           <= max_d;
         spread_q        <= spread_d;
         done_q          <= done_d;
         timeout_error_q <= timeout_error_d;
         result_value_q  <= result_value_d;
      end
   end

   assign resultValue  = result_value_q;
   assign spread       = spread_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign timeoutError = timeout_error_q;

endmodule
